// File: rtl/ft245_hsk_fifo_bridge_pkg.sv
// Shared definitions for the FT245 handshake-to-FIFO bridge:
// data width and the RX/TX interlock state encodings.
package ft245_hsk_fifo_bridge_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        RX_IDLE,
        RX_ACK
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_REQ,
        TX_WAIT
    } tx_state_t;

endpackage

// File: rtl/ft245_hsk_fifo_bridge_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// The head reads as zero while empty so the output is defined from reset.
module fpga_io_sync_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = count[DEPTH_LOG2];
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ft245_hsk_fifo_bridge.sv
// Bridges the FT245 controller's four-phase RX/TX req/ack interlocks onto
// two independent valid/ready byte FIFOs; all handshake outputs are registered.
module ft245_hsk_fifo_bridge
    import ft245_hsk_fifo_bridge_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_rx_hsk_req,
    input  logic [7:0]            in_rx_data,
    output logic                  out_rx_hsk_ack,
    output logic                  out_rx_en,
    output logic                  out_tx_hsk_req,
    output logic [7:0]            out_tx_data,
    input  logic                  in_tx_hsk_ack,
    output logic                  out_rx_valid,
    output logic [7:0]            out_rx_byte,
    input  logic                  in_rx_ready,
    input  logic                  in_tx_valid,
    input  logic [7:0]            in_tx_byte,
    output logic                  out_tx_ready,
    output logic [DEPTH_LOG2:0]   out_rx_count,
    output logic [DEPTH_LOG2:0]   out_tx_count
);

    localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);

    rx_state_t             rx_state, rx_state_d;
    tx_state_t             tx_state, tx_state_d;
    logic                  rx_ack_d;
    logic                  rx_en_d;
    logic                  rx_push;
    logic                  rx_pop;
    logic                  rx_full;
    logic                  rx_empty;
    logic [DEPTH_LOG2:0]   rx_count_next;
    logic                  tx_req_d;
    logic [BYTE_W-1:0]     tx_data_d;
    logic                  tx_pop;
    logic                  tx_full;
    logic                  tx_empty;
    logic [BYTE_W-1:0]     tx_head;

    fpga_io_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(BYTE_W)) u_rx_fifo (
        .clk       (in_clk),
        .rst_n     (in_rst_n),
        .push      (rx_push),
        .push_data (in_rx_data),
        .pop       (rx_pop),
        .head      (out_rx_byte),
        .count     (out_rx_count),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    fpga_io_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(BYTE_W)) u_tx_fifo (
        .clk       (in_clk),
        .rst_n     (in_rst_n),
        .push      (in_tx_valid),
        .push_data (in_tx_byte),
        .pop       (tx_pop),
        .head      (tx_head),
        .count     (out_tx_count),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    assign out_rx_valid = ~rx_empty;
    assign out_tx_ready = ~tx_full;
    assign rx_pop       = in_rx_ready & ~rx_empty;

    // rx_en is derived from next-cycle occupancy/state so it never reads high
    // while a byte is being acknowledged or the FIFO has just filled.
    assign rx_count_next = out_rx_count
                         + (DEPTH_LOG2 + 1)'(rx_push & ~rx_full)
                         - (DEPTH_LOG2 + 1)'(rx_pop);
    assign rx_en_d = (rx_count_next < DEPTH_C) && (rx_state_d == RX_IDLE);

    always_comb begin
        rx_state_d = rx_state;
        rx_ack_d   = out_rx_hsk_ack;
        rx_push    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (in_rx_hsk_req) begin
                    rx_push    = 1'b1;
                    rx_ack_d   = 1'b1;
                    rx_state_d = RX_ACK;
                end
            end
            RX_ACK: begin
                if (!in_rx_hsk_req) begin
                    rx_ack_d   = 1'b0;
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_ack_d   = 1'b0;
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    always_comb begin
        tx_state_d = tx_state;
        tx_req_d   = out_tx_hsk_req;
        tx_data_d  = out_tx_data;
        tx_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_req_d   = 1'b1;
                    tx_data_d  = tx_head;
                    tx_state_d = TX_REQ;
                end
            end
            TX_REQ: begin
                if (in_tx_hsk_ack) begin
                    tx_req_d   = 1'b0;
                    tx_pop     = 1'b1;
                    tx_state_d = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (!in_tx_hsk_ack) begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: begin
                tx_req_d   = 1'b0;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            rx_state       <= RX_IDLE;
            out_rx_hsk_ack <= 1'b0;
            out_rx_en      <= 1'b0;
            tx_state       <= TX_IDLE;
            out_tx_hsk_req <= 1'b0;
            out_tx_data    <= '0;
        end else begin
            rx_state       <= rx_state_d;
            out_rx_hsk_ack <= rx_ack_d;
            out_rx_en      <= rx_en_d;
            tx_state       <= tx_state_d;
            out_tx_hsk_req <= tx_req_d;
            out_tx_data    <= tx_data_d;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst_n && rx_push) begin
            assert (!rx_full) else $error("RX push into full FIFO");
        end
    end

endmodule
